// File: rtl/eq1_if.sv
// Bundle of the eq1 sample input and result/statistics outputs.
// Handshake: valid-only. A sample {a,b,c,d} is taken on every rising clk
// edge where in_valid=1; there is no ready, the block accepts one sample per
// cycle forever. out_valid=1 marks the single cycle in which o/idx show the
// result of the sample accepted on the previous edge.
interface eq1_if;
  logic        in_valid;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        o;
  logic        out_valid;
  logic [3:0]  idx;
  logic [15:0] seen;
  logic        all_seen;
  logic [7:0]  ones_cnt;

  // Sample producer side (bench or upstream logic).
  modport master (
    output in_valid, a, b, c, d,
    input  o, out_valid, idx, seen, all_seen, ones_cnt
  );

  // The eq1 block itself.
  modport slave (
    input  in_valid, a, b, c, d,
    output o, out_valid, idx, seen, all_seen, ones_cnt
  );
endinterface

// File: rtl/eq1.sv
// eq1: registered evaluation of o = (~a & b) | (c & d) over a stream of
// 4-bit minterms {a,b,c,d}, plus coverage (seen/all_seen) and a saturating
// count of samples whose result was 1.
module eq1 (
  input  logic  clk,
  input  logic  rst,
  eq1_if.slave  bus
);

  logic [3:0]  idx_in;
  logic        eq_res;
  logic        o_q;
  logic        out_valid_q;
  logic [3:0]  idx_q;
  logic [15:0] seen_q;
  logic [7:0]  ones_cnt_q;

  assign idx_in = {bus.a, bus.b, bus.c, bus.d};
  assign eq_res = (~bus.a & bus.b) | (bus.c & bus.d);

  // One-cycle valid pulse following each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= bus.in_valid;
  end

  // Result and index registers; they hold through idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q   <= 1'b0;
      idx_q <= 4'd0;
    end else if (bus.in_valid) begin
      o_q   <= eq_res;
      idx_q <= idx_in;
    end
  end

  // Sticky minterm coverage; bits only ever get set outside reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               seen_q <= 16'h0000;
    else if (bus.in_valid) seen_q <= seen_q | (16'h0001 << idx_in);
  end

  // Count of ones, saturating at 255 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             ones_cnt_q <= 8'd0;
    else if (bus.in_valid && eq_res && ones_cnt_q != 8'hFF) ones_cnt_q <= ones_cnt_q + 8'd1;
  end

  assign bus.o         = o_q;
  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.seen      = seen_q;
  assign bus.all_seen  = &seen_q;
  assign bus.ones_cnt  = ones_cnt_q;

endmodule

// File: tb/tb_eq1.sv
// Directed bench for eq1: reset, full minterm sweep, idle gap, saturation,
// mid-stream reset and reset-vs-valid collision.
module tb_eq1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  eq1_if bus ();

  eq1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // o for minterm k is bit k: minterms 3,4,5,6,7,11,15 give 1.
  localparam logic [15:0] O_TABLE = 16'h88F8;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one minterm at the falling edge, wait for the capturing edge.
  task automatic drive(input logic v, input logic [3:0] m);
    @(negedge clk);
    bus.in_valid = v;
    {bus.a, bus.b, bus.c, bus.d} = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_o"},        {15'd0, bus.o},         16'd0);
    check({tag, "_ov"},       {15'd0, bus.out_valid}, 16'd0);
    check({tag, "_idx"},      {12'd0, bus.idx},       16'd0);
    check({tag, "_seen"},     bus.seen,               16'd0);
    check({tag, "_all_seen"}, {15'd0, bus.all_seen},  16'd0);
    check({tag, "_ones"},     {8'd0, bus.ones_cnt},   16'd0);
  endtask

  initial begin
    logic [15:0] tbl;
    int          exp_ones;
    n_checks = 0;
    n_fail   = 0;
    tbl      = O_TABLE;
    rst      = 1'b1;
    bus.in_valid = 1'b0;
    {bus.a, bus.b, bus.c, bus.d} = 4'd0;

    // Reset state
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sweep all 16 minterms in order
    exp_ones = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'(k));
      if (tbl[k]) exp_ones++;
      check($sformatf("sweep_ov_%0d", k),  {15'd0, bus.out_valid}, 16'd1);
      check($sformatf("sweep_o_%0d", k),   {15'd0, bus.o},         {15'd0, tbl[k]});
      check($sformatf("sweep_idx_%0d", k), {12'd0, bus.idx},       16'(k));
    end
    check("sweep_ones",     {8'd0, bus.ones_cnt},  16'(exp_ones));
    check("sweep_ones_7",   {8'd0, bus.ones_cnt},  16'd7);
    check("sweep_all_seen", {15'd0, bus.all_seen}, 16'd1);
    check("sweep_seen",     bus.seen,              16'hFFFF);

    // Gap: minterm 3 then two idle cycles
    drive(1'b1, 4'd3);
    check("gap_ov0",  {15'd0, bus.out_valid}, 16'd1);
    check("gap_o0",   {15'd0, bus.o},         16'd1);
    check("gap_idx0", {12'd0, bus.idx},       16'd3);
    check("gap_ones", {8'd0, bus.ones_cnt},   16'd8);
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 4'd9);
      check($sformatf("gap_ov%0d", i),   {15'd0, bus.out_valid}, 16'd0);
      check($sformatf("gap_o%0d", i),    {15'd0, bus.o},         16'd1);
      check($sformatf("gap_idx%0d", i),  {12'd0, bus.idx},       16'd3);
      check($sformatf("gap_ones%0d", i), {8'd0, bus.ones_cnt},   16'd8);
    end

    // Five samples (5,0,7,11,12 -> three ones), then an async reset pulse
    drive(1'b1, 4'd5);
    drive(1'b1, 4'd0);
    drive(1'b1, 4'd7);
    drive(1'b1, 4'd11);
    drive(1'b1, 4'd12);
    check("pre_rst_ones", {8'd0, bus.ones_cnt}, 16'd11);
    check("pre_rst_idx",  {12'd0, bus.idx},     16'd12);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ov",   {15'd0, bus.out_valid}, 16'd0);
    check("post_rst_seen", bus.seen,               16'd0);
    check("post_rst_ones", {8'd0, bus.ones_cnt},   16'd0);

    // Saturation: minterm 15 for 300 cycles
    @(negedge clk);
    bus.in_valid = 1'b1;
    {bus.a, bus.b, bus.c, bus.d} = 4'd15;
    repeat (300) @(posedge clk);
    #1;
    check("sat_ones",     {8'd0, bus.ones_cnt},  16'd255);
    check("sat_seen",     bus.seen,              16'h8000);
    check("sat_all_seen", {15'd0, bus.all_seen}, 16'd0);
    check("sat_ov",       {15'd0, bus.out_valid}, 16'd1);
    check("sat_o",        {15'd0, bus.o},        16'd1);
    drive(1'b1, 4'd15);
    check("sat_hold", {8'd0, bus.ones_cnt}, 16'd255);

    // Reset and a valid minterm 4 at the same edge: reset wins
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    {bus.a, bus.b, bus.c, bus.d} = 4'd4;
    @(posedge clk);
    #1;
    check_all_zero("collide");
    // First edge with rst=0 and in_valid=1 accepts
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_ov",   {15'd0, bus.out_valid}, 16'd1);
    check("first_o",    {15'd0, bus.o},         16'd1);
    check("first_idx",  {12'd0, bus.idx},       16'd4);
    check("first_seen", bus.seen,               16'h0010);
    check("first_ones", {8'd0, bus.ones_cnt},   16'd1);
    drive(1'b0, 4'd0);
    check("idle_ov",   {15'd0, bus.out_valid}, 16'd0);
    check("idle_idx",  {12'd0, bus.idx},       16'd4);
    check("idle_ones", {8'd0, bus.ones_cnt},   16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eq1.md
EQ1 -- requirements
Module: eq1

Interface
REQ-001 The block SHALL expose port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL expose port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL expose port in_valid, input, 1 bit: qualifies a/b/c/d in the current cycle.
REQ-004 The block SHALL expose ports a, b, c, d, input, 1 bit each: equation operands, with a as the MSB of the minterm index.
REQ-005 The block SHALL expose port o, output, 1 bit: registered equation result.
REQ-006 The block SHALL expose port out_valid, output, 1 bit: o, idx and the counters reflect a new sample.
REQ-007 The block SHALL expose port idx, output, 4 bits: registered minterm index {a,b,c,d} of the last accepted sample.
REQ-008 The block SHALL expose port seen, output, 16 bits: bit k is set once minterm k has been accepted.
REQ-009 The block SHALL expose port all_seen, output, 1 bit: asserted when seen == 16'hFFFF.
REQ-010 The block SHALL expose port ones_cnt, output, 8 bits: count of accepted samples whose result was 1.

Function
REQ-011 The equation SHALL be o = (~a & b) | (c & d), i.e. o=1 exactly for minterms 3,4,5,6,7,11,15 and o=0 for minterms 0,1,2,8,9,10,12,13,14.
REQ-012 A sample SHALL be accepted on each rising clk edge where in_valid=1; no back-pressure, one sample per cycle sustained.
REQ-013 Latency SHALL be exactly one cycle: the cycle after acceptance, out_valid=1 and o/idx hold that sample's result/index.
REQ-014 When in_valid=0 at an edge, out_valid SHALL be 0 next cycle, while o, idx, seen and ones_cnt hold their values.
REQ-015 On acceptance, seen[{a,b,c,d}] SHALL be set; bits SHALL be set only, never cleared except by reset.
REQ-016 all_seen SHALL be combinationally derived from seen, with no extra latency beyond the seen update.
REQ-017 On acceptance with result 1, ones_cnt SHALL increment by 1, saturating at 255 (no wrap-around).
REQ-018 Repeated acceptance of the same minterm SHALL leave seen unchanged and SHALL increment ones_cnt only if the result is 1.
REQ-019 Any input value containing X/Z SHALL NOT be required to produce defined behaviour; the bench drives only 0/1.

Reset
REQ-020 While rst=1, regardless of clk, the outputs SHALL be o=0, out_valid=0, idx=0, seen=0, all_seen=0 and ones_cnt=0.
REQ-021 Reset asserted mid-stream SHALL discard any sample presented in that cycle; no output pulse SHALL follow reset release.
REQ-022 After rst deasserts, the first acceptance SHALL occur on the first rising edge with rst=0 and in_valid=1.
REQ-023 Reset SHALL take priority over in_valid at any edge where both are active.

Verification
REQ-024 The bench SHALL, after reset, sweep all 16 minterms 0..15 in order with in_valid=1 for one cycle each, and SHALL require out_valid=1 each following cycle, the o sequence 0,0,0,1,1,1,1,1,0,0,0,1,0,0,0,1, ones_cnt=7 at the end and all_seen=1 after minterm 15.
REQ-025 The bench SHALL cover a gap: accept minterm 3, then drive in_valid=0 for 2 cycles, and SHALL require out_valid=1,0,0 with o=1 and idx=3 held.
REQ-026 The bench SHALL cover saturation: accept minterm 15 for 300 consecutive cycles, and SHALL require ones_cnt=255 with seen=16'h8000.
REQ-027 The bench SHALL cover reset mid-operation: after 5 accepted samples, pulse rst between edges, and SHALL require all outputs 0 immediately and seen=0 after release.
REQ-028 The bench SHALL cover simultaneous events: drive rst=1 with in_valid=1 on minterm 4, and SHALL require out_valid=0, seen=0 and ones_cnt=0 on the following cycle.
